controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have no parameters; all encodings come from ktc32_pkg.
REQ-002 SHALL have port: clk  in  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high.
REQ-004 SHALL have port: op  in  6  instr[5:0] from the instruction register; op[0]=1 marks a 32-bit instruction with a 16-bit immediate.
REQ-005 SHALL have port: zero  in  1  ALU zero flag.
REQ-006 SHALL have outputs pcen, iord, irwrite, memtoreg, regwrite, alusrca, pcsrc, memwrite, illegal, each 1 bit, matching the datapath controls of the same names; illegal is a 1-cycle flag.
REQ-007 SHALL have outputs alusrcb (2 bits; 00=b, 01=pc increment, 10=zero, 11=imm) and alucontrol (3 bits).
REQ-008 SHALL have port memready  in  1  memory access complete, present only under KTC32_MEMWAIT_EN.

Function
REQ-009 SHALL decode this opcode map:
- op[5:4]=00, op[0]=0: ALU R-type, alucontrol=op[3:1] (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 slt).
- op=0x01 LW; 0x03 SW; 0x05 BEQ; 0x07 BNE; 0x09 JMP; 0x0B ADDI.
- Any other op is illegal.
REQ-010 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP.
REQ-011 FETCH SHALL drive iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=0, pcen=1, then go to DECODE.
REQ-012 DECODE SHALL assert no enables, then go to: EXEC (R-type), EXECI (ADDI), MEMADR (LW/SW), BRANCH (BEQ/BNE), JUMP (JMP), or FETCH (illegal).
REQ-013 An illegal op SHALL pulse illegal=1 during DECODE only.
REQ-014 EXEC SHALL drive alusrca=1, alusrcb=00, alucontrol=op[3:1], then go to ALUWB.
REQ-015 EXECI SHALL drive alusrca=1, alusrcb=11, alucontrol=add, then go to ALUWB.
REQ-016 ALUWB SHALL drive regwrite=1, memtoreg=0, then go to FETCH.
REQ-017 MEMADR SHALL drive alusrca=1, alusrcb=11, alucontrol=add, then go to MEMRD (LW) or MEMWR (SW).
REQ-018 MEMRD SHALL drive iord=1, then go to MEMWB.
REQ-019 MEMWB SHALL drive regwrite=1, memtoreg=1, then go to FETCH.
REQ-020 MEMWR SHALL drive iord=1, memwrite=1, then go to FETCH.
REQ-021 BRANCH SHALL drive alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=1, and pcen=zero (BEQ) or pcen=~zero (BNE), then go to FETCH.
REQ-022 JUMP SHALL drive pcsrc=1, pcen=1, then go to FETCH.
REQ-023 Every output not named for a state SHALL be 0 in that state; pcen SHALL be the only output depending on zero.
REQ-024 Instruction latency in cycles SHALL be: R/ADDI 4, LW 5, SW 4, BEQ/BNE 3, JMP 3, illegal 2 (without wait states).

Reset
REQ-025 While reset=1, pcen, irwrite, regwrite, memwrite and illegal SHALL be 0, and the next state SHALL be FETCH.
REQ-026 Reset asserted in any state, including mid-instruction, SHALL abort the instruction with no register or memory write.

Configuration
REQ-027 With KTC32_MEMWAIT_EN defined, FETCH, MEMRD and MEMWR SHALL hold state and keep iord/memwrite stable until memready=1.
REQ-028 Under KTC32_MEMWAIT_EN, FETCH SHALL gate irwrite and pcen with memready.
REQ-029 Without KTC32_MEMWAIT_EN, the memready port SHALL be absent and every memory state SHALL last exactly 1 cycle.

Structure
REQ-030 ktc32_pkg SHALL hold the state enum, opcode constants, alucontrol constants and alusrcb constants.
REQ-031 The module SHALL be a single module with no sub-module: state register plus combinational next-state and output logic.

Verification
REQ-032 R-type: op=0x06 (or) after reset -> states FETCH,DECODE,EXEC,ALUWB; alucontrol=011 in EXEC; regwrite=1 only in cycle 4.
REQ-033 LW: op=0x01 -> iord=1 in cycle 4; regwrite=1 and memtoreg=1 in cycle 5; memwrite never asserted.
REQ-034 Branch: BEQ op=0x05 with zero=1 -> pcen=1, pcsrc=1 in cycle 3; with zero=0 -> pcen=0; BNE op=0x07 with zero=0 -> pcen=1.
REQ-035 Illegal: op=0x3F -> illegal=1 in cycle 2, no regwrite/memwrite, FETCH in cycle 3.
REQ-036 Reset during MEMWR (SW op=0x03, reset=1 in cycle 4) -> memwrite=0 in that cycle, FETCH next cycle.
REQ-037 KTC32_MEMWAIT_EN: memready=0 for 3 cycles in FETCH -> irwrite=pcen=0 for those cycles, iord stays 0, and irwrite=pcen=1 in the cycle memready=1.

Source files
------------

// File: rtl/ktc32_pkg.sv
// Shared encodings for the KTC32 multicycle controller: FSM states,
// opcode constants, ALU operation codes and ALU B-operand selects.
package ktc32_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC,
        EXECI,
        ALUWB,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        BRANCH,
        JUMP
    } state_t;

    localparam logic [5:0] OP_LW   = 6'h01;
    localparam logic [5:0] OP_SW   = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h05;
    localparam logic [5:0] OP_BNE  = 6'h07;
    localparam logic [5:0] OP_JMP  = 6'h09;
    localparam logic [5:0] OP_ADDI = 6'h0B;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_INC  = 2'b01;
    localparam logic [1:0] SRCB_ZERO = 2'b10;
    localparam logic [1:0] SRCB_IMM  = 2'b11;

    // R-type instructions occupy the short-form, even opcodes 0x00..0x0E.
    function automatic logic is_rtype(input logic [5:0] op);
        return (op[5:4] == 2'b00) && !op[0];
    endfunction

endpackage

// File: rtl/controller.sv
// KTC32 multicycle Moore controller: a state register plus combinational
// next-state and output decode. Optional memory wait states are enabled by
// defining KTC32_MEMWAIT_EN, which adds the memready input and lets FETCH,
// MEMRD and MEMWR stall until the memory reports completion.
module controller
    import ktc32_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
`ifdef KTC32_MEMWAIT_EN
    input  logic       memready,
`endif
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcsrc,
    output logic       memwrite,
    output logic       illegal,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol
);

    state_t state;
    state_t state_next;
    logic   mem_ok;

`ifdef KTC32_MEMWAIT_EN
    assign mem_ok = memready;
`else
    assign mem_ok = 1'b1;
`endif

    // State register; reset always returns to FETCH on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; memory states hold until the access completes.
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = mem_ok ? DECODE : FETCH;
            DECODE: begin
                if (is_rtype(op))                      state_next = EXEC;
                else if (op == OP_ADDI)                state_next = EXECI;
                else if (op == OP_LW || op == OP_SW)   state_next = MEMADR;
                else if (op == OP_BEQ || op == OP_BNE) state_next = BRANCH;
                else if (op == OP_JMP)                 state_next = JUMP;
                else                                   state_next = FETCH;
            end
            EXEC:    state_next = ALUWB;
            EXECI:   state_next = ALUWB;
            ALUWB:   state_next = FETCH;
            MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_next = mem_ok ? MEMWB : MEMRD;
            MEMWB:   state_next = FETCH;
            MEMWR:   state_next = mem_ok ? FETCH : MEMWR;
            BRANCH:  state_next = FETCH;
            JUMP:    state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Output decode from the current state; reset forces every write enable low.
    always_comb begin
        pcen       = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        pcsrc      = 1'b0;
        memwrite   = 1'b0;
        illegal    = 1'b0;
        alusrcb    = SRCB_B;
        alucontrol = ALU_ADD;
        case (state)
            FETCH: begin
                irwrite = mem_ok;
                pcen    = mem_ok;
                alusrcb = SRCB_INC;
            end
            DECODE: begin
                illegal = !(is_rtype(op) || op == OP_ADDI || op == OP_LW ||
                            op == OP_SW || op == OP_BEQ || op == OP_BNE ||
                            op == OP_JMP);
            end
            EXEC: begin
                alusrca    = 1'b1;
                alucontrol = op[3:1];
            end
            EXECI, MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            ALUWB: begin
                regwrite = 1'b1;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 1'b1;
                pcen       = (op == OP_BEQ) ? zero : !zero;
            end
            JUMP: begin
                pcsrc = 1'b1;
                pcen  = 1'b1;
            end
            default: begin
                pcen = 1'b0;
            end
        endcase
        if (reset) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for the KTC32 controller: directed instruction
// sequences with literal expectations, then randomized instruction streams
// with occasional mid-instruction resets, compared every cycle against a
// per-instruction step model.
module tb_controller;

    localparam logic [13:0] ALL_MASK = 14'h3FFF;
    // pcen, irwrite, regwrite, memwrite, illegal
    localparam logic [13:0] RST_MASK = 14'b10_1010_0110_0000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
`ifdef KTC32_MEMWAIT_EN
    logic       memready;
`endif
    logic       pcen, iord, irwrite, memtoreg, regwrite, alusrca, pcsrc, memwrite, illegal;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;

    logic [13:0] dut_vec;
    logic [13:0] exp_vec;
    logic [13:0] exp_mask;
    logic        exp_valid = 1'b0;
    logic [13:0] seen [0:7];

    int errors = 0;
    int checks = 0;

    controller dut (
        .clk(clk),
        .reset(reset),
        .op(op),
        .zero(zero),
`ifdef KTC32_MEMWAIT_EN
        .memready(memready),
`endif
        .pcen(pcen),
        .iord(iord),
        .irwrite(irwrite),
        .memtoreg(memtoreg),
        .regwrite(regwrite),
        .alusrca(alusrca),
        .pcsrc(pcsrc),
        .memwrite(memwrite),
        .illegal(illegal),
        .alusrcb(alusrcb),
        .alucontrol(alucontrol)
    );

    always #5 clk = ~clk;

    assign dut_vec = {pcen, iord, irwrite, memtoreg, regwrite, alusrca, pcsrc,
                      memwrite, illegal, alusrcb, alucontrol};

    // Instruction classes: 0 R, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 JMP, 7 illegal
    function automatic int kind_of(input logic [5:0] o);
        if (o[5:4] == 2'b00 && o[0] == 1'b0) return 0;
        case (o)
            6'h0B:   return 1;
            6'h01:   return 2;
            6'h03:   return 3;
            6'h05:   return 4;
            6'h07:   return 5;
            6'h09:   return 6;
            default: return 7;
        endcase
    endfunction

    function automatic int latency(input int k);
        case (k)
            0, 1, 3:    return 4;
            2:          return 5;
            4, 5, 6:    return 3;
            default:    return 2;
        endcase
    endfunction

    function automatic bit is_mem_step(input logic [5:0] o, input int step);
        int k;
        k = kind_of(o);
        return (step == 0) || (step == 3 && (k == 2 || k == 3));
    endfunction

    // Expected control vector for a given step of an instruction.
    function automatic logic [13:0] model_out(input logic [5:0] o, input int step,
                                              input logic z, input logic rdy);
        logic p_en, i_d, ir_w, m2r, r_w, s_a, p_s, m_w, ill;
        logic [1:0] s_b;
        logic [2:0] alu;
        int k;
        k = kind_of(o);
        {p_en, i_d, ir_w, m2r, r_w, s_a, p_s, m_w, ill} = 9'b0;
        s_b = 2'b00;
        alu = 3'b000;
        if (step == 0) begin
            ir_w = rdy;
            p_en = rdy;
            s_b  = 2'b01;
        end else if (step == 1) begin
            ill = (k == 7);
        end else begin
            case (k)
                0: if (step == 2) begin s_a = 1'b1; alu = o[3:1]; end else r_w = 1'b1;
                1: if (step == 2) begin s_a = 1'b1; s_b = 2'b11; end else r_w = 1'b1;
                2: begin
                    if (step == 2) begin s_a = 1'b1; s_b = 2'b11; end
                    else if (step == 3) i_d = 1'b1;
                    else begin r_w = 1'b1; m2r = 1'b1; end
                end
                3: begin
                    if (step == 2) begin s_a = 1'b1; s_b = 2'b11; end
                    else begin i_d = 1'b1; m_w = 1'b1; end
                end
                4, 5: begin
                    s_a  = 1'b1;
                    alu  = 3'b001;
                    p_s  = 1'b1;
                    p_en = (k == 4) ? z : ~z;
                end
                6: begin p_s = 1'b1; p_en = 1'b1; end
                default: ill = 1'b0;
            endcase
        end
        return {p_en, i_d, ir_w, m2r, r_w, s_a, p_s, m_w, ill, s_b, alu};
    endfunction

    task automatic check_output(input string name, input logic [13:0] actual,
                                input logic [13:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, required);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic [5:0] o, input logic z,
                                  input logic rdy, input logic [13:0] e, input logic [13:0] m);
        @(posedge clk);
        #1;
        reset = r;
        op    = o;
        zero  = z;
`ifdef KTC32_MEMWAIT_EN
        memready = rdy;
`endif
        exp_vec   = e;
        exp_mask  = m;
        exp_valid = 1'b1;
    endtask

    // Cycle-by-cycle comparison against the model expectation.
    always @(negedge clk) begin
        if (exp_valid) check_output("ctrl_vec", dut_vec & exp_mask, exp_vec & exp_mask);
    end

    // Runs one instruction; abort_step >= 0 asserts reset in that step.
    // zmode 0/1 fixes zero, 2 randomizes it every cycle.
    task automatic run_instr(input logic [5:0] o, input int abort_step,
                             input bit allow_stall, input int zmode);
        int lat;
        int step;
        int stalls;
        logic z;
        logic rdy;
        lat = latency(kind_of(o));
        step = 0;
        stalls = 0;
        while (step < lat) begin
            z = (zmode == 2) ? logic'($urandom_range(0, 1)) : (zmode == 1);
            rdy = 1'b1;
`ifdef KTC32_MEMWAIT_EN
            if (allow_stall && is_mem_step(o, step) && stalls < 4 && $urandom_range(0, 1) == 0)
                rdy = 1'b0;
`else
            if (allow_stall && is_mem_step(o, step)) rdy = 1'b1;
`endif
            if (step == abort_step) begin
                apply_stimulus(1'b1, o, z, rdy, 14'h0, RST_MASK);
                @(negedge clk);
                #1;
                seen[step] = dut_vec;
                return;
            end
            apply_stimulus(1'b0, o, z, rdy, model_out(o, step, z, rdy), ALL_MASK);
            @(negedge clk);
            #1;
            seen[step] = dut_vec;
            if (rdy) begin
                step++;
                stalls = 0;
            end else begin
                stalls++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] o;
        logic [13:0] any_mw;
        int ab;
        reset = 1'b1;
        op    = 6'h00;
        zero  = 1'b0;
`ifdef KTC32_MEMWAIT_EN
        memready = 1'b1;
`endif
        // Reset held: all write enables must be low
        apply_stimulus(1'b1, 6'h00, 1'b0, 1'b1, 14'h0, RST_MASK);
        apply_stimulus(1'b1, 6'h00, 1'b1, 1'b1, 14'h0, RST_MASK);
        @(negedge clk);
        #1;
        check_output("reset_enables", dut_vec & RST_MASK, 14'h0);

        // R-type OR
        run_instr(6'h06, -1, 1'b0, 0);
        check_output("or_fetch_irwrite", {13'b0, seen[0][11]}, 14'd1);
        check_output("or_exec_aluc", {11'b0, seen[2][2:0]}, 14'b011);
        check_output("or_regwrite_c4", {13'b0, seen[3][9]}, 14'd1);
        check_output("or_regwrite_c1to3", {11'b0, seen[0][9], seen[1][9], seen[2][9]}, 14'd0);

        // LW
        run_instr(6'h01, -1, 1'b0, 0);
        any_mw = '0;
        for (int i = 0; i < 5; i++) any_mw = any_mw | {13'b0, seen[i][6]};
        check_output("lw_iord_c4", {13'b0, seen[3][12]}, 14'd1);
        check_output("lw_wb_c5", {12'b0, seen[4][9], seen[4][10]}, 14'b11);
        check_output("lw_no_memwrite", any_mw, 14'd0);

        // Branches
        run_instr(6'h05, -1, 1'b0, 1);
        check_output("beq_z1_pcen_pcsrc", {12'b0, seen[2][13], seen[2][7]}, 14'b11);
        run_instr(6'h05, -1, 1'b0, 0);
        check_output("beq_z0_pcen", {13'b0, seen[2][13]}, 14'd0);
        run_instr(6'h07, -1, 1'b0, 0);
        check_output("bne_z0_pcen", {13'b0, seen[2][13]}, 14'd1);

        // Illegal
        run_instr(6'h3F, -1, 1'b0, 0);
        check_output("ill_pulse_c2", {12'b0, seen[0][5], seen[1][5]}, 14'b01);
        check_output("ill_no_writes", {12'b0, seen[1][9], seen[1][6]}, 14'd0);
        run_instr(6'h0B, -1, 1'b0, 0);
        check_output("ill_then_fetch", {11'b0, seen[0][11], seen[0][4:3]}, 14'b101);

        // Reset during MEMWR of SW
        run_instr(6'h03, 3, 1'b0, 0);
        check_output("sw_reset_memwrite", {13'b0, seen[3][6]}, 14'd0);
        run_instr(6'h00, -1, 1'b0, 0);
        check_output("sw_reset_fetch", {11'b0, seen[0][11], seen[0][4:3]}, 14'b101);

`ifdef KTC32_MEMWAIT_EN
        // FETCH stalled three cycles by memory
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 6'h09, 1'b0, 1'b0, model_out(6'h09, 0, 1'b0, 1'b0), ALL_MASK);
            @(negedge clk);
            #1;
            check_output("wait_fetch_stall", {11'b0, irwrite, pcen, iord}, 14'b000);
        end
        apply_stimulus(1'b0, 6'h09, 1'b0, 1'b1, model_out(6'h09, 0, 1'b0, 1'b1), ALL_MASK);
        @(negedge clk);
        #1;
        check_output("wait_fetch_ready", {11'b0, irwrite, pcen, iord}, 14'b110);
        apply_stimulus(1'b0, 6'h09, 1'b0, 1'b1, model_out(6'h09, 1, 1'b0, 1'b1), ALL_MASK);
        apply_stimulus(1'b0, 6'h09, 1'b0, 1'b1, model_out(6'h09, 2, 1'b0, 1'b1), ALL_MASK);
        @(negedge clk);
`endif

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       o = {2'b00, 3'($urandom_range(0, 7)), 1'b0};
                1:       o = 6'h01;
                2:       o = 6'h03;
                3:       o = 6'h05;
                4:       o = 6'h07;
                5:       o = 6'h09;
                6:       o = 6'h0B;
                default: o = 6'($urandom_range(0, 63));
            endcase
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, latency(kind_of(o)) - 1) : -1;
            run_instr(o, ab, 1'b1, 2);
        end

        exp_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
